// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_if
// Description : Request/response bus between a load/store requester and
//               the data-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : RV32I byte-addressed data memory controller with optional
//               wait states. Define DMEM_MISALIGN_CHK_EN to fault misaligned
//               halfword/word accesses instead of force-aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  wire logic clk,
    input  wire logic rst,
    dmem_if.slave     bus
);

    localparam int         c_AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rword;

    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic            w_accept;
    logic [1:0]      w_size;
    logic            w_ill;
    logic            w_oob;
    logic            w_mis;
    logic            w_err;
    logic [1:0]      w_lane;
    logic [c_AW-1:0] w_idx;
    logic [3:0]      w_be;
    logic [31:0]     w_wbus;
    logic [31:0]     w_shift;
    logic [31:0]     w_load;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_WS_LOAD;
                    end else begin
                        w_state_nxt = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Request fields are frozen at acceptance; the bus may change afterwards.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_we    <= bus.req_we;
            r_f3    <= bus.req_funct3;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end
    end

    // ---------------- decode ----------------
    always_comb begin
        w_size = r_f3[1:0];
        w_ill  = r_we ? (r_f3 > 3'd2)
                      : ((r_f3 == 3'd3) || (r_f3[2:1] == 2'b11));
        w_oob  = (r_addr[31:2] >= 30'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_CHK_EN
        w_mis  = ((w_size == 2'd1) && r_addr[0]) ||
                 ((w_size == 2'd2) && (r_addr[1:0] != 2'b00));
        w_lane = r_addr[1:0];
`else
        w_mis  = 1'b0;
        w_lane = (w_size == 2'd2) ? 2'b00 :
                 (w_size == 2'd1) ? {r_addr[1], 1'b0} : r_addr[1:0];
`endif
        w_err  = w_ill || w_oob || w_mis;
        w_idx  = r_addr[c_AW+1:2];

        case (w_size)
            2'd0:    begin w_wbus = {4{r_wdata[7:0]}};  w_be = 4'b0001 << w_lane; end
            2'd1:    begin w_wbus = {2{r_wdata[15:0]}}; w_be = 4'b0011 << w_lane; end
            default: begin w_wbus = r_wdata;            w_be = 4'b1111;           end
        endcase

        w_shift = r_rword >> {w_lane, 3'b000};
        case (r_f3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    // ---------------- storage ----------------
    // A reset landing on the access edge also cancels the write.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_ACCESS)) begin
            if (r_we && !w_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[i]) begin
                        r_mem[w_idx][8*i +: 8] <= w_wbus[8*i +: 8];
                    end
                end
            end
            r_rword <= r_mem[w_idx];
        end
    end

    // ---------------- response ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_rsp_valid <= (r_state == S_RESP);
            r_rsp_err   <= (r_state == S_RESP) && w_err;
            r_rsp_rdata <= ((r_state == S_RESP) && !w_err && !r_we) ? w_load : 32'd0;
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Randomized self-checking bench for dmem_ctrl against a
//               byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    localparam int DEPTH = 256;
    localparam int WS    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    logic [7:0] mref [DEPTH*4];

    dmem_if bus ();

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-level reference: little-endian bytes, size from funct3[1:0].
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int          n;
        logic        legal;
        logic [31:0] a;
        logic [31:0] ext;
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
        er    = !legal || (addr[31:2] >= 30'(DEPTH));
        a     = addr - (addr % 32'(n));
`ifdef DMEM_MISALIGN_CHK_EN
        if (legal && (a != addr)) er = 1'b1;
`endif
        rd = 32'd0;
        if (!er) begin
            if (we) begin
                for (int b = 0; b < n; b++) mref[int'(a) + b] = wdata[8*b +: 8];
            end else begin
                for (int b = 0; b < n; b++) rd = rd | (32'(mref[int'(a) + b]) << (8*b));
                if (!f3[2] && (n < 4) && rd[8*n-1]) begin
                    ext = 32'hFFFF_FFFF;
                    rd  = rd | (ext << (8*n));
                end
            end
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    // Present a request, wait for acceptance, then scramble the bus.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
        int waited = 0;
        @(negedge clk);
        drive(we, f3, addr, wdata);
        bus.req_valid = 1'b1;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        drive(1'($urandom), 3'($urandom), $urandom, $urandom);
    endtask

    // Count edges after the accept edge until rsp_valid is seen.
    task automatic wait_rsp(output logic [31:0] rd, output logic er, output int lat);
        int busy_bad  = 0;
        int quiet_bad = 0;
        lat = 0;
        rd  = 32'd0;
        er  = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) begin
                lat = e;
                rd  = bus.rsp_rdata;
                er  = bus.rsp_err;
                break;
            end
            if (bus.req_ready) busy_bad++;
            if ((bus.rsp_rdata != 32'd0) || bus.rsp_err) quiet_bad++;
        end
        check("busy_ready", 32'(busy_bad), 32'd0);
        check("idle_outputs", 32'(quiet_bad), 32'd0);
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        logic        eer;
        int          lat;
        model(we, f3, addr, wdata, erd, eer);
        send(we, f3, addr, wdata);
        wait_rsp(rd, er, lat);
        check("latency", 32'(lat), 32'(WS + 2));
        check("rdata", rd, erd);
        check("err", 32'(er), 32'(eer));
    endtask

    initial begin : main
        logic [31:0] rd, erd, erd2;
        logic        er, eer, eer2;
        int          lat;
        int          cnt;
        logic [31:0] addr;

        // Reset with a request pending: must not be taken.
        bus.req_valid = 1'b1;
        drive(1'b1, 3'b010, 32'h0, 32'h1111_1111);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_no_accept", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < DEPTH; i++) run(1'b1, 3'b010, 32'(i*4), $urandom, rd, er);

        // Directed sequences
        run(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er);
        check("d_sw_err", 32'(er), 32'd0);
        run(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
        check("d_lw", rd, 32'hDEAD_BEEF);
        run(1'b1, 3'b000, 32'h13, 32'h0000_0080, rd, er);
        run(1'b0, 3'b000, 32'h13, 32'h0, rd, er);
        check("d_lb", rd, 32'hFFFF_FF80);
        run(1'b0, 3'b100, 32'h13, 32'h0, rd, er);
        check("d_lbu", rd, 32'h0000_0080);
        run(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
        check("d_lw_merge", rd, 32'h80AD_BEEF);
        run(1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, rd, er);
        check("d_oob_err", 32'(er), 32'd1);
        run(1'b0, 3'b010, 32'h0, 32'h0, rd, er);
        run(1'b1, 3'b011, 32'h0, 32'h1234_5678, rd, er);
        check("d_ill_err", 32'(er), 32'd1);
        check("d_ill_rdata", rd, 32'd0);

        // Second request held high across the first one's processing.
        model(1'b0, 3'b010, 32'h40, 32'h0, erd, eer);
        model(1'b0, 3'b001, 32'h46, 32'h0, erd2, eer2);
        @(negedge clk);
        drive(1'b0, 3'b010, 32'h40, 32'h0);
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 3'b001, 32'h46, 32'h0);
        wait_rsp(rd, er, lat);
        check("held_lat_a", 32'(lat), 32'(WS + 2));
        check("held_rdata_a", rd, erd);
        check("held_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_rsp(rd, er, lat);
        check("held_lat_b", 32'(lat), 32'(WS + 2));
        check("held_rdata_b", rd, erd2);

        // Reset during WAIT aborts the store.
        @(negedge clk);
        drive(1'b1, 3'b010, 32'h20, 32'h5555_5555);
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("abort_busy", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", 32'(bus.req_ready), 32'd1);
        cnt = 0;
        for (int e = 0; e < 8; e++) begin
            if (bus.rsp_valid) cnt++;
            @(posedge clk);
            #1;
        end
        check("abort_no_rsp", 32'(cnt), 32'd0);
        run(1'b0, 3'b010, 32'h20, 32'h0, rd, er);

        // Misaligned halfword load.
        run(1'b1, 3'b010, 32'h20, 32'h1234_8765, rd, er);
        run(1'b0, 3'b001, 32'h21, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_CHK_EN
        check("d_lh_mis_err", 32'(er), 32'd1);
        check("d_lh_mis_rdata", rd, 32'd0);
`else
        check("d_lh_mis_err", 32'(er), 32'd0);
        check("d_lh_mis_rdata", rd, 32'hFFFF_8765);
`endif

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = 32'h400 + 32'($urandom_range(0, 15));
                default: addr = 32'($urandom_range(0, DEPTH*4 - 1));
            endcase
            run(1'($urandom), 3'($urandom_range(0, 7)), addr, $urandom, rd, er);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
